interrupt_injector: RTL

CPU-side receiver for the interrupt instructions produced by the frame/key input controller. It captures each one-cycle, non-zero 32-bit interrupt instruction pulse into a small FIFO and holds it there until the processor can take it. It then presents the instruction to the fetch stage through a valid/ready handshake. After each handshake it blocks further injection until the handler signals return, so interrupt handlers never nest.

---
 rtl/interrupt_injector_if.sv | 26 ++
 rtl/interrupt_injector.sv | 124 ++++++++++++
 2 files changed

// File: rtl/interrupt_injector_if.sv
// Fetch-side interrupt injection bus: request capture, valid/ready offer and status.
// The slave modport is the injector; the master modport is whatever drives it.
interface interrupt_injector_if #(
  parameter int CNT_W = 3
) ();
  logic [31:0]      interrupt_instruction;
  logic             irq_enable;
  logic             inject_ready;
  logic             irq_return;
  logic             overflow_clr;
  logic             inject_valid;
  logic [31:0]      inject_instruction;
  logic             in_service;
  logic [CNT_W-1:0] pending_count;
  logic             overflow;

  modport slave (
    input  interrupt_instruction, irq_enable, inject_ready, irq_return, overflow_clr,
    output inject_valid, inject_instruction, in_service, pending_count, overflow
  );

  modport master (
    output interrupt_instruction, irq_enable, inject_ready, irq_return, overflow_clr,
    input  inject_valid, inject_instruction, in_service, pending_count, overflow
  );
endinterface

// File: rtl/interrupt_injector.sv
// Queues non-zero interrupt instruction pulses and injects them one at a time into fetch,
// blocking until irq_return. Define INJECT_COALESCE_EN to drop requests already queued.
module interrupt_injector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                 proc_clk_i,
  input  logic                 reset_i,
  interrupt_injector_if.slave  bus_if
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OFFER   = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [31:0]      slot_data [DEPTH];
  logic             coalesce_hit;
  logic             push_req, push, pop, full, drop;

  // Each slot is its own register so the whole queue clears on reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [31:0] slot_q;

      always_ff @(posedge proc_clk_i or posedge reset_i) begin
        if (reset_i) begin
          slot_q <= '0;
        end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
          slot_q <= bus_if.interrupt_instruction;
        end
      end

      assign slot_data[gi] = slot_q;
    end
  endgenerate

`ifdef INJECT_COALESCE_EN
  logic [DEPTH-1:0] match;

  // A slot is live when its distance from the read pointer is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offset;
      assign offset    = PTR_W'(gi) - rd_ptr_q;
      assign match[gi] = (CNT_W'(offset) < count_q) &&
                         (slot_data[gi] == bus_if.interrupt_instruction);
    end
  endgenerate

  assign coalesce_hit = |match;
`else
  assign coalesce_hit = 1'b0;
`endif

  assign push_req = (bus_if.interrupt_instruction != 32'd0) && !coalesce_hit;
  assign pop      = (state_q == ST_OFFER) && bus_if.inject_ready;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = drop ? 1'b1 : (bus_if.overflow_clr ? 1'b0 : overflow_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && bus_if.irq_enable) begin
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // An accepted handshake completes even if the enable drops in that cycle.
        if (bus_if.inject_ready) begin
          state_d = ST_SERVICE;
        end else if (!bus_if.irq_enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus_if.irq_return) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge proc_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus_if.inject_valid       = (state_q == ST_OFFER);
  assign bus_if.inject_instruction = (state_q == ST_OFFER) ? slot_data[rd_ptr_q] : 32'd0;
  assign bus_if.in_service         = (state_q == ST_SERVICE);
  assign bus_if.pending_count      = count_q;
  assign bus_if.overflow           = overflow_q;

endmodule
